// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, operation, operandA, operandB,
    input  busy, done, result
  );

  modport slave (
    input  start, operation, operandA, operandB,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: fixed WIDTH-cycle latency,
// operands converted to magnitudes at capture and sign-corrected on the last step.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      count_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic               div_zero_reg;
  logic               overflow_reg;
  logic [WIDTH-1:0]   result_reg;

  // Capture-side decode: which operands are treated as signed for this op.
  logic             is_div_in;
  logic             signed_a_in;
  logic             signed_b_in;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;

  always_comb begin
    is_div_in   = bus.operation[2];
    signed_a_in = is_div_in ? ~bus.operation[0]
                            : (bus.operation == 3'b001 || bus.operation == 3'b010);
    signed_b_in = is_div_in ? ~bus.operation[0] : (bus.operation == 3'b001);
    neg_a_in    = signed_a_in & bus.operandA[WIDTH-1];
    neg_b_in    = signed_b_in & bus.operandB[WIDTH-1];
    a_mag_in    = neg_a_in ? -bus.operandA : bus.operandA;
    b_mag_in    = neg_b_in ? -bus.operandB : bus.operandB;
  end

  // One iteration. The accumulator holds {product_hi, multiplier} when
  // multiplying and {remainder, dividend/quotient} when dividing.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_shl;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
    mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                          : {1'b0, acc_reg[2*WIDTH-1:1]};
    div_shl  = {acc_reg, 1'b0};
    div_diff = div_shl[2*WIDTH:WIDTH] - {1'b0, mcand_reg};
    div_next = div_diff[WIDTH] ? div_shl[2*WIDTH-1:0]
                               : {div_diff[WIDTH-1:0], div_shl[WIDTH-1:1], 1'b1};
    acc_next = op_reg[2] ? div_next : mul_next;
  end

  // Final-step sign correction and output selection.
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quot_fin;
  logic [WIDTH-1:0]   rem_fin;
  logic [WIDTH-1:0]   result_sel;

  always_comb begin
    prod_fin = (neg_a_reg ^ neg_b_reg) ? -acc_next : acc_next;
    if (div_zero_reg) begin
      quot_fin = '1;
      rem_fin  = a_raw_reg;
    end else if (overflow_reg) begin
      quot_fin = {1'b1, {(WIDTH-1){1'b0}}};
      rem_fin  = '0;
    end else begin
      quot_fin = (neg_a_reg ^ neg_b_reg) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      rem_fin  = neg_a_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end
    case (op_reg)
      3'b000:                 result_sel = prod_fin[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_sel = prod_fin[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_sel = quot_fin;
      default:                result_sel = rem_fin;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      op_reg       <= '0;
      mcand_reg    <= '0;
      acc_reg      <= '0;
      a_raw_reg    <= '0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      overflow_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        CALC: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            result_reg <= result_sel;
            state_reg  <= DONE;
          end
        end
        default: begin
          if (bus.start) begin
            op_reg       <= bus.operation;
            a_raw_reg    <= bus.operandA;
            neg_a_reg    <= neg_a_in;
            neg_b_reg    <= neg_b_in;
            // Divide takes the divisor as the subtrahend; multiply adds A.
            mcand_reg    <= is_div_in ? b_mag_in : a_mag_in;
            acc_reg      <= {{WIDTH{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
            div_zero_reg <= is_div_in && (bus.operandB == '0);
            overflow_reg <= is_div_in && !bus.operation[0]
                            && (bus.operandA == {1'b1, {(WIDTH-1){1'b0}}})
                            && (bus.operandB == '1);
            count_reg    <= '0;
            state_reg    <= CALC;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state_reg == CALC);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency and
// control-behaviour checks, one line per completed transaction.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   passes;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] value;
    int          cap;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input bit track);
    exp_t e;
    bus.start     = 1'b1;
    bus.operation = op;
    bus.operandA  = a;
    bus.operandB  = b;
    if (track) begin
      e.name  = name;
      e.value = expv;
      e.cap   = cycle + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      $display("FAIL %s_timeout: got no done, required done within 40 cycles", name);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] expv);
    issue(name, op, a, b, expv, 1'b1);
    wait_done(name);
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done with result %h, required no done", bus.result);
        end else begin
          e = sb.pop_front();
          $display("txn %s result=%h expected=%h latency=%0d", e.name, bus.result, e.value, cycle - e.cap);
          chk({e.name, "_result"}, bus.result, e.value);
          chk({e.name, "_latency"}, 32'(cycle - e.cap), 32'd32);
        end
      end
    end
  end

  initial begin
    int bc;
    int pulses;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.operation = 3'b000;
    bus.operandA = '0;
    bus.operandB = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Signed MUL with busy held for exactly 32 sampled cycles before done.
    issue("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    bc = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) bc++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(bc), 32'd32);
    chk("mul_done_busy_low", {31'd0, bus.busy}, 32'd0);
    wait_done("mul");
    @(negedge clk);

    run("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    run("mul_big", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780);
    run("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC);
    run("divu_by0", 3'b101, 32'h00001234, 32'd0,      32'hFFFFFFFF);
    run("remu_by0", 3'b111, 32'h00001234, 32'd0,      32'h00001234);
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // start pulse mid-CALC must be ignored; result holds the previous value.
    issue("ignore", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.operation = 3'b000;
    bus.operandA = 32'd3;
    bus.operandB = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("calc_result_held", bus.result, 32'h00000000);
    wait_done("ignore");
    @(negedge clk);
    chk("ignored_start_no_op", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: second start presented during the DONE cycle.
    issue("b2b_first", 3'b000, 32'd6, 32'd7, 32'd42, 1'b1);
    wait_done("b2b_first");
    issue("b2b_second", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset 10 cycles into CALC abandons the operation.
    issue("aborted", 3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    run("after_reset", 3'b000, 32'd5, 32'd6, 32'd30);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
